preset_bank_sequencer: RTL and testbench

- Controller for a bank of negative-edge D flops with active-low asynchronous set, split into NGROUPS set domains.
- Gates the bank's clock and drives one SETN line per group.
- Performs preset on request, or automatically out of reset, with staggered per-group SETN release to limit simultaneous switching.
- Sits between the power/reset controller and the flop bank; uses a 4-phase REQ/ACK handshake.

---
 rtl/preset_bank_sequencer.sv | 142 ++++++++++++++
 tb/tb_preset_bank_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/preset_bank_sequencer.sv
// Preset sequencer for a negedge flop bank with per-group active-low async set.
// Gates the bank clock and releases SETN groups one at a time to limit simultaneous switching.
module preset_bank_sequencer #(
    parameter int unsigned NGROUPS     = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic               CLK,
    input  logic               RN,
    input  logic               REQ,
    input  logic [NGROUPS-1:0] MASK,
    output logic               ACK,
    output logic               BUSY,
    output logic               CLK_EN,
    output logic [NGROUPS-1:0] SETN_OUT
);

    localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StGate    = 3'd1;
    localparam logic [2:0] StAssert  = 3'd2;
    localparam logic [2:0] StRelease = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // Groups still waiting for release; bits are cleared as each group goes high.
    logic [NGROUPS-1:0] mask_q, mask_d;
    logic [NGROUPS-1:0] setn_q, setn_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               clk_en_q, clk_en_d;
    // Set when the running sequence came out of reset, so completion skips ACK.
    logic               auto_q, auto_d;
    logic [NGROUPS-1:0] low_bit;

    assign low_bit = mask_q & (~mask_q + NGROUPS'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        setn_d   = setn_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        clk_en_d = clk_en_q;
        auto_d   = auto_q;

        case (state_q)
            StIdle: begin
                if (REQ) begin
                    busy_d = 1'b1;
                    auto_d = 1'b0;
                    if (MASK != '0) begin
                        mask_d   = MASK;
                        clk_en_d = 1'b0;
                        state_d  = StGate;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StGate: begin
                setn_d  = setn_q & ~mask_q;
                cnt_d   = '0;
                state_d = StAssert;
            end
            StAssert: begin
                if (cnt_q == HoldLast) begin
                    setn_d  = setn_q | low_bit;
                    mask_d  = mask_q & ~low_bit;
                    cnt_d   = '0;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (mask_q != '0) begin
                        setn_d = setn_q | low_bit;
                        mask_d = mask_q & ~low_bit;
                    end else begin
                        clk_en_d = 1'b1;
                        if (auto_q) begin
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = StDone;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (!REQ) begin
                    ack_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= StAssert;
            cnt_q    <= '0;
            mask_q   <= '1;
            setn_q   <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b1;
            clk_en_q <= 1'b0;
            auto_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            setn_q   <= setn_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            clk_en_q <= clk_en_d;
            auto_q   <= auto_d;
        end
    end

    assign ACK      = ack_q;
    assign BUSY     = busy_q;
    assign CLK_EN   = clk_en_q;
    assign SETN_OUT = setn_q;

endmodule

// File: tb/tb_preset_bank_sequencer.sv
// Scoreboard bench for preset_bank_sequencer: expected per-edge outputs come from release formulas.
module tb_preset_bank_sequencer;

    localparam int H = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rn;
    logic       req;
    logic [3:0] mask;
    logic       ack_a, busy_a, clk_en_a;
    logic [3:0] setn_a;

    logic       req_off = 1'b0;
    logic [0:0] mask_b  = '0;
    logic [7:0] mask_c  = '0;
    logic       ack_b, busy_b, clk_en_b;
    logic [0:0] setn_b;
    logic       ack_c, busy_c, clk_en_c;
    logic [7:0] setn_c;

    always #5 clk = ~clk;

    preset_bank_sequencer dut_a (
        .CLK(clk), .RN(rn), .REQ(req), .MASK(mask),
        .ACK(ack_a), .BUSY(busy_a), .CLK_EN(clk_en_a), .SETN_OUT(setn_a)
    );

    preset_bank_sequencer #(.NGROUPS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .CLK(clk), .RN(rn), .REQ(req_off), .MASK(mask_b),
        .ACK(ack_b), .BUSY(busy_b), .CLK_EN(clk_en_b), .SETN_OUT(setn_b)
    );

    preset_bank_sequencer #(.NGROUPS(8), .HOLD_CYCLES(1), .GAP_CYCLES(5)) dut_c (
        .CLK(clk), .RN(rn), .REQ(req_off), .MASK(mask_c),
        .ACK(ack_c), .BUSY(busy_c), .CLK_EN(clk_en_c), .SETN_OUT(setn_c)
    );

    typedef struct packed {
        logic        ack;
        logic        busy;
        logic        clk_en;
        logic [15:0] setn;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t obs_a();
        return {ack_a, busy_a, clk_en_a, 12'b0, setn_a};
    endfunction

    function automatic exp_t obs_b();
        return {ack_b, busy_b, clk_en_b, 15'b0, setn_b};
    endfunction

    function automatic exp_t obs_c();
        return {ack_c, busy_c, clk_en_c, 8'b0, setn_c};
    endfunction

    // k = number of CLK rises since RN went high.
    function automatic exp_t post_exp(input int n, input int h, input int g, input int k);
        exp_t e;
        int   c;
        c        = h + n * g;
        e.ack    = 1'b0;
        e.busy   = (k < c);
        e.clk_en = (k >= c);
        e.setn   = '0;
        for (int i = 0; i < n; i++) e.setn[i] = (k >= h + i * g);
        return e;
    endfunction

    // j = edge index relative to the sampling edge E0; REQ is sampled 0 at edges after r.
    function automatic exp_t req_exp(input logic [3:0] m, input int r, input int j);
        exp_t e;
        int   rel[4];
        int   idx;
        int   c;
        int   d;
        e.setn = 16'h000f;
        if (m == 4'b0) begin
            d        = (r + 1 > 1) ? r + 1 : 1;
            e.ack    = (j < d);
            e.busy   = (j < d);
            e.clk_en = 1'b1;
            return e;
        end
        idx = 0;
        for (int g = 0; g < 4; g++) begin
            rel[g] = 0;
            if (m[g]) begin
                rel[g] = 1 + H + idx * G;
                idx++;
            end
        end
        c        = 1 + H + idx * G;
        d        = (r + 1 > c + 1) ? r + 1 : c + 1;
        e.clk_en = (j >= c);
        e.busy   = (j < d);
        e.ack    = (j >= c) && (j < d);
        for (int g = 0; g < 4; g++)
            if (m[g] && j >= 1 && j < rel[g]) e.setn[g] = 1'b0;
        return e;
    endfunction

    // Called at a negedge in IDLE; REQ drops #1 after edge r, MASK changes #1 after edge mc.
    task automatic run_req(input string tag, input logic [3:0] m, input int r, input int mc,
                           input logic [3:0] new_mask, input int n);
        exp_t e;
        req  = 1'b1;
        mask = m;
        for (int j = 0; j < n; j++) q_a.push_back(req_exp(m, r, j));
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            if (j == r) req = 1'b0;
            if (j == mc) mask = new_mask;
            @(negedge clk);
            e = q_a.pop_front();
            check($sformatf("%s E%0d", tag, j), 32'(obs_a()), 32'(e));
        end
    endtask

    task automatic run_post(input int n_edges, input bit sweep);
        exp_t e;
        for (int k = 1; k <= n_edges; k++) begin
            q_a.push_back(post_exp(4, H, G, k));
            if (sweep) begin
                q_b.push_back(post_exp(1, 1, 1, k));
                q_c.push_back(post_exp(8, 1, 5, k));
            end
        end
        for (int k = 1; k <= n_edges; k++) begin
            @(posedge clk);
            @(negedge clk);
            e = q_a.pop_front();
            check($sformatf("post_a k=%0d", k), 32'(obs_a()), 32'(e));
            if (sweep) begin
                e = q_b.pop_front();
                check($sformatf("post_b k=%0d", k), 32'(obs_b()), 32'(e));
                e = q_c.pop_front();
                check($sformatf("post_c k=%0d", k), 32'(obs_c()), 32'(e));
            end
        end
    endtask

    // Invariants on the default-size bank, sampled at every falling CLK edge.
    logic [3:0] prev_setn   = 4'h0;
    logic       prev_busy   = 1'b1;
    logic       prev_clk_en = 1'b0;
    logic       prev_rn     = 1'b0;

    always @(negedge clk) begin
        if (rn) begin
            check("inv_clk_en_while_set", 32'((|(~setn_a)) & clk_en_a), 32'd0);
            if (prev_rn) begin
                check("inv_one_rise", 32'($countones(setn_a & ~prev_setn) <= 1), 32'd1);
                check("inv_fall_only_on_assert",
                      32'((|(prev_setn & ~setn_a)) &&
                          !(prev_setn == 4'hf && prev_busy && !prev_clk_en)), 32'd0);
            end
        end
        prev_setn   = setn_a;
        prev_busy   = busy_a;
        prev_clk_en = clk_en_a;
        prev_rn     = rn;
    end

    localparam exp_t RstExp = '{ack: 1'b0, busy: 1'b1, clk_en: 1'b0, setn: 16'h0};

    initial begin
        rn   = 1'b0;
        req  = 1'b0;
        mask = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'(obs_a()), 32'(RstExp));
        check("reset_b", 32'(obs_b()), 32'(RstExp));
        check("reset_c", 32'(obs_c()), 32'(RstExp));
        rn = 1'b1;

        // Default bank plus the NGROUPS=1 and NGROUPS=8 sweep instances out of reset.
        run_post(45, 1'b1);

        run_req("req_0101", 4'b0101, 11, -1, 4'b0, 15);
        run_req("req_zero", 4'b0000, 2, -1, 4'b0, 5);
        run_req("req_0001_chg", 4'b0001, 3, 3, 4'b1111, 10);

        // Abort a full-bank request with RN at E6.
        run_req("req_1111_abort", 4'b1111, 100, -1, 4'b0, 7);
        #1;
        rn  = 1'b0;
        req = 1'b0;
        #1;
        check("abort_async", 32'(obs_a()), 32'(RstExp));
        @(posedge clk);
        #1;
        check("abort_hold", 32'(obs_a()), 32'(RstExp));
        @(posedge clk);
        #1;
        rn = 1'b1;
        run_post(14, 1'b0);

        run_req("req_1000_early_drop", 4'b1000, 0, -1, 4'b0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
